// File: rtl/i2s_pkg.sv
// i2s_pkg: shared stereo sample type and transmit FIFO state encoding
package i2s_pkg;
  localparam int I2S_DW = 24;
  typedef struct packed {logic [I2S_DW-1:0] l, r;} stereo_t;
  typedef enum logic {FILL, RUN} txfifo_state_t;
endpackage

// File: rtl/i2s_sample_ram.sv
// i2s_sample_ram: simple dual-port RAM, one write port and one registered read port
// Ports: clk; we/waddr/wdata write port; re/raddr read request; rdata registered read data (holds when re=0)
module i2s_sample_ram #(
  parameter int W     = 48,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/i2s_tx_fifo.sv
// i2s_tx_fifo: primed stereo sample FIFO feeding the i2s transmitter, with underflow muting
// Ports: clk, rst (sync, active-high); s_ldata/s_rdata/s_valid/s_ready write stream;
//        tx_rd_en request in, tx_ldata/tx_rdata/tx_rd_valid response (latency 1);
//        level, almost_empty status; underflow/overflow 1-cycle pulses.
// Build option: define I2S_TX_FIFO_HOLD_EN to repeat the last served pair on underflow
//               instead of muting to zero.
module i2s_tx_fifo
  import i2s_pkg::*;
#(
  parameter int DW           = I2S_DW,
  parameter int DEPTH        = 16,
  parameter int PRIME_LEVEL  = 4,
  parameter int AEMPTY_LEVEL = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] s_ldata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          tx_rd_en,
  output logic [DW-1:0] tx_ldata,
  output logic [DW-1:0] tx_rdata,
  output logic          tx_rd_valid,
  output logic [LW-1:0] level,
  output logic          almost_empty,
  output logic          underflow,
  output logic          overflow
);
  txfifo_state_t   state;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [2*DW-1:0] ram_q;
  logic            out_zero;
  logic            accept, served;
  assign s_ready      = level != LW'(DEPTH);
  assign almost_empty = level <= LW'(AEMPTY_LEVEL);
  assign accept       = s_valid && s_ready;
  assign served       = tx_rd_en && state == RUN && level != '0 && !rst;
  // The RAM read register holds between requests; out_zero masks it to zero after
  // reset (RAM contents are not reset) and, in the mute build, after an underflow.
  assign {tx_ldata, tx_rdata} = out_zero ? '0 : ram_q;
  i2s_sample_ram #(.W(2*DW), .DEPTH(DEPTH)) u_ram (
    .clk   (clk),
    .we    (accept && !rst),
    .waddr (wr_ptr),
    .wdata ({s_ldata, s_rdata}),
    .re    (served),
    .raddr (rd_ptr),
    .rdata (ram_q)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      out_zero    <= 1'b1;
      tx_rd_valid <= 1'b0;
      underflow   <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      tx_rd_valid <= served;
      underflow   <= tx_rd_en && !served;
      overflow    <= s_valid && !s_ready;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (served) rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(accept) - LW'(served);
`ifdef I2S_TX_FIFO_HOLD_EN
      if (served) out_zero <= 1'b0;
`else
      if (tx_rd_en) out_zero <= !served;
`endif
      state <= state == FILL ? (level >= LW'(PRIME_LEVEL) ? RUN : FILL)
                             : (tx_rd_en && !served ? FILL : RUN);
    end
  end
endmodule

// File: tb/tb_i2s_tx_fifo.sv
// tb_i2s_tx_fifo: directed scenarios plus random traffic checked against a queue-based model
module tb_i2s_tx_fifo;
`ifdef I2S_TX_FIFO_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] s_ldata = '0, s_rdata = '0;
  logic        s_valid = 1'b0, tx_rd_en = 1'b0;
  logic        s_ready, tx_rd_valid, almost_empty, underflow, overflow;
  logic [23:0] tx_ldata, tx_rdata;
  logic [4:0]  level;
  int total = 0, bad = 0;

  // reference model: FIFO contents as a queue, priming flag, expected registered outputs
  logic [47:0] q[$];
  bit          primed = 0;
  logic [47:0] e_data = '0, last = '0;
  bit          e_valid = 0, e_uf = 0, e_of = 0;

  i2s_tx_fifo dut (
    .clk(clk), .rst(rst), .s_ldata(s_ldata), .s_rdata(s_rdata), .s_valid(s_valid),
    .s_ready(s_ready), .tx_rd_en(tx_rd_en), .tx_ldata(tx_ldata), .tx_rdata(tx_rdata),
    .tx_rd_valid(tx_rd_valid), .level(level), .almost_empty(almost_empty),
    .underflow(underflow), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // model of one clock edge, using input values present before the edge
  task automatic model_edge();
    int  n;
    bit  serve, unserved, was_primed;
    if (rst) begin
      q.delete();
      primed = 0; e_data = '0; last = '0; e_valid = 0; e_uf = 0; e_of = 0;
      return;
    end
    n          = q.size();
    was_primed = primed;
    serve      = tx_rd_en && was_primed && n != 0;
    unserved   = tx_rd_en && !serve;
    e_valid    = serve;
    e_uf       = unserved;
    e_of       = s_valid && n == 16;
    if (serve) begin
      e_data = q.pop_front();
      last   = e_data;
    end else if (unserved) e_data = HOLD ? last : 48'h0;
    if (s_valid && n != 16) q.push_back({s_ldata, s_rdata});
    primed = was_primed ? !unserved : n >= 4;
  endtask

  task automatic step(input bit r, input bit v, input bit req, input logic [23:0] l, input logic [23:0] rr, input bit full_chk);
    rst = r; s_valid = v; tx_rd_en = req; s_ldata = l; s_rdata = rr;
    @(posedge clk);
    model_edge();
    #1;
    chk("level", 64'(level), 64'(q.size()));
    chk("tx_rd_valid", 64'(tx_rd_valid), 64'(e_valid));
    chk("underflow", 64'(underflow), 64'(e_uf));
    chk("overflow", 64'(overflow), 64'(e_of));
    chk("tx_data", {16'h0, tx_ldata, tx_rdata}, {16'h0, e_data});
    if (full_chk) begin
      chk("s_ready", 64'(s_ready), 64'(q.size() != 16));
      chk("almost_empty", 64'(almost_empty), 64'(q.size() <= 2));
    end
  endtask

  task automatic wr(input logic [23:0] l, input logic [23:0] rr); step(0, 1, 0, l, rr, 1); endtask
  task automatic rq(); step(0, 0, 1, '0, '0, 1); endtask
  task automatic idle(); step(0, 0, 0, '0, '0, 1); endtask
  task automatic reset(); step(1, 0, 0, '0, '0, 1); endtask

  initial begin
    // 1: request before priming is refused, level kept
    reset();
    chk("reset_ready", 64'(s_ready), 64'(1));
    chk("reset_aempty", 64'(almost_empty), 64'(1));
    for (int i = 0; i < 3; i++) wr(24'h100 + 24'(i), 24'h200 + 24'(i));
    idle(); idle();
    rq();
    chk("t1_uf", 64'(underflow), 64'(1));
    chk("t1_data", {16'h0, tx_ldata, tx_rdata}, 64'h0);
    chk("t1_level", 64'(level), 64'(3));
    // 2: six pairs returned in order
    reset();
    for (int i = 0; i < 6; i++) wr(24'h000001 + 24'(i), 24'h800001 + 24'(i));
    idle();
    for (int i = 0; i < 6; i++) begin
      rq();
      chk("t2_pair", {16'h0, tx_ldata, tx_rdata}, {16'h0, 24'h000001 + 24'(i), 24'h800001 + 24'(i)});
      idle();
    end
    chk("t2_level", 64'(level), 64'(0));
    chk("t2_aempty", 64'(almost_empty), 64'(1));
    // 3: fill to 16 and hold a 17th pair
    reset();
    for (int i = 0; i < 16; i++) wr(24'h300 + 24'(i), 24'h400 + 24'(i));
    chk("t3_full_ready", 64'(s_ready), 64'(0));
    wr(24'hDEAD00, 24'hBEEF00);
    chk("t3_ovf", 64'(overflow), 64'(1));
    wr(24'hDEAD00, 24'hBEEF00);
    for (int i = 0; i < 17; i++) rq();
    chk("t3_uf_after_drain", 64'(underflow), 64'(1));
    // 4: write and serve together at level 1
    reset();
    for (int i = 0; i < 4; i++) wr(24'h500 + 24'(i), 24'h600 + 24'(i));
    idle();
    for (int i = 0; i < 3; i++) rq();
    step(0, 1, 1, 24'h5AA, 24'h6AA, 1);
    chk("t4_level", 64'(level), 64'(1));
    chk("t4_head", {16'h0, tx_ldata, tx_rdata}, {16'h0, 24'h503, 24'h603});
    // 5: drain, underflow, refill resumes
    rq(); rq();
    chk("t5_uf", 64'(underflow), 64'(1));
    chk("t5_data", {16'h0, tx_ldata, tx_rdata}, HOLD ? {16'h0, 24'h5AA, 24'h6AA} : 64'h0);
    wr(24'h700, 24'h800);
    rq();
    chk("t5_fill_refuse", 64'(tx_rd_valid), 64'(0));
    for (int i = 1; i < 4; i++) wr(24'h700 + 24'(i), 24'h800 + 24'(i));
    idle();
    rq();
    chk("t5_resume", {15'h0, tx_rd_valid, tx_ldata, tx_rdata}, {15'h0, 1'b1, 24'h700, 24'h800});
    // 6: reset with a request while level is 8
    reset();
    for (int i = 0; i < 8; i++) wr(24'h900 + 24'(i), 24'hA00 + 24'(i));
    idle();
    step(1, 0, 1, '0, '0, 1);
    chk("t6_level", 64'(level), 64'(0));
    chk("t6_valid", 64'(tx_rd_valid), 64'(0));
    idle();
    chk("t6_no_pulse", 64'(tx_rd_valid), 64'(0));
    // random traffic, alternating producer- and consumer-heavy phases
    for (int p = 0; p < 12; p++) begin
      for (int c = 0; c < 150; c++) begin
        step(($urandom_range(0, 299) == 0), ($urandom_range(0, 99) < (p[0] ? 30 : 75)),
             ($urandom_range(0, 99) < (p[0] ? 70 : 30)), 24'($urandom), 24'($urandom), 1);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
